// File: rtl/alu_serial_pkg.sv
// Shared types and helpers for the digit-serial ALU.
package alu_serial_pkg;

    localparam int DIGIT_MAX = 16;

    typedef enum logic [1:0] {
        OP_NONE  = 2'd0,
        OP_AND   = 2'd1,
        OP_XOR   = 2'd2,
        OP_ARITH = 2'd3
    } op_e;

    // Resolve the one-hot-ish op pins with ARITH > XOR > AND priority.
    function automatic op_e op_decode(input logic arith, input logic xr, input logic an);
        if (arith) begin
            return OP_ARITH;
        end else if (xr) begin
            return OP_XOR;
        end else if (an) begin
            return OP_AND;
        end
        return OP_NONE;
    endfunction

endpackage

// File: rtl/alu_serial_digit.sv
// Combinational DIGIT-wide slice: add / xor / and on one digit of the word.
module alu_serial_digit
    import alu_serial_pkg::*;
#(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] x_i,
    input  logic [DIGIT-1:0] y_i,
    input  logic             c_i,
    input  op_e              op_i,
    output logic [DIGIT-1:0] sum_o,
    output logic             c_out_o,
    output logic             c_into_msb_o
);

    logic [DIGIT:0] add_w;

    assign add_w = {1'b0, x_i} + {1'b0, y_i} + {{DIGIT{1'b0}}, c_i};

    // Select the digit result; carries are only meaningful for ARITH.
    always_comb begin
        sum_o        = '0;
        c_out_o      = 1'b0;
        c_into_msb_o = 1'b0;
        case (op_i)
            OP_ARITH: begin
                sum_o        = add_w[DIGIT-1:0];
                c_out_o      = add_w[DIGIT];
                // The MSB sum bit is x^y^cin, so cin is recovered without a second adder.
                c_into_msb_o = add_w[DIGIT-1] ^ x_i[DIGIT-1] ^ y_i[DIGIT-1];
            end
            OP_XOR:  sum_o = x_i ^ y_i;
            OP_AND:  sum_o = x_i & y_i;
            default: sum_o = '0;
        endcase
    end

endmodule

// File: rtl/alu_serial.sv
// Digit-serial ALU: framed words, LSB digit first, 2-cycle pipeline, carry loop
// closed in stage 2 so back-to-back digits see the previous digit's carry.
module alu_serial
    import alu_serial_pkg::*;
#(
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             in_first,
    input  logic             in_last,
    input  logic [DIGIT-1:0] X,
    input  logic [DIGIT-1:0] Y,
    input  logic             Carry_in,
    input  logic             Cmpl_X,
    input  logic             Cmpl_Y,
    input  logic             Op_XOR,
    input  logic             Op_AND,
    input  logic             Op_ARITH,
    output logic             out_valid,
    output logic             out_last,
    output logic [DIGIT-1:0] Sum,
    output logic             Carry_out,
    output logic             Overflow,
    output logic             Zero
);

    // Word controls latched on the first digit
    logic cin_lat_q, cin_lat_d;
    logic cmplx_lat_q, cmplx_lat_d;
    logic cmply_lat_q, cmply_lat_d;
    op_e  op_lat_q, op_lat_d;
    logic open_q, open_d;

    // Stage 1
    logic             vld_p1_q, vld_p1_d;
    logic             first_p1_q, first_p1_d;
    logic             last_p1_q, last_p1_d;
    logic             cin_p1_q, cin_p1_d;
    op_e              op_p1_q, op_p1_d;
    logic [DIGIT-1:0] x_p1_q, x_p1_d;
    logic [DIGIT-1:0] y_p1_q, y_p1_d;

    // Stage 2 and the carry / zero loop
    logic             carry_q, carry_d;
    logic             zacc_q, zacc_d;
    logic             vld_p2_q, vld_p2_d;
    logic             last_p2_q, last_p2_d;
    logic [DIGIT-1:0] sum_p2_q, sum_p2_d;
    logic             co_p2_q, co_p2_d;
    logic             ov_p2_q, ov_p2_d;
    logic             z_p2_q, z_p2_d;

    logic             start_w;
    logic             accept_w;
    logic             cmplx_w;
    logic             cmply_w;
    logic             c_use_w;
    logic [DIGIT-1:0] sum_w;
    logic             cout_w;
    logic             cmsb_w;
    logic             zero_w;
    logic             arith_w;

    // Input framing: capture controls on in_first, drop digits outside a word.
    always_comb begin
        start_w     = in_valid & in_first;
        accept_w    = in_valid & (in_first | open_q);
        cin_lat_d   = cin_lat_q;
        cmplx_lat_d = cmplx_lat_q;
        cmply_lat_d = cmply_lat_q;
        op_lat_d    = op_lat_q;
        if (start_w) begin
            cin_lat_d   = Carry_in;
            cmplx_lat_d = Cmpl_X;
            cmply_lat_d = Cmpl_Y;
            op_lat_d    = op_decode(Op_ARITH, Op_XOR, Op_AND);
        end
        open_d     = accept_w ? ~in_last : open_q;
        cmplx_w    = start_w ? Cmpl_X : cmplx_lat_q;
        cmply_w    = start_w ? Cmpl_Y : cmply_lat_q;
        vld_p1_d   = accept_w;
        first_p1_d = in_first;
        last_p1_d  = in_last;
        cin_p1_d   = cin_lat_d;
        op_p1_d    = op_lat_d;
        x_p1_d     = X ^ {DIGIT{cmplx_w}};
        y_p1_d     = Y ^ {DIGIT{cmply_w}};
    end

    // Latched word controls and stage-1 control flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cin_lat_q   <= 1'b0;
            cmplx_lat_q <= 1'b0;
            cmply_lat_q <= 1'b0;
            op_lat_q    <= OP_NONE;
            open_q      <= 1'b0;
            vld_p1_q    <= 1'b0;
            first_p1_q  <= 1'b0;
            last_p1_q   <= 1'b0;
            cin_p1_q    <= 1'b0;
            op_p1_q     <= OP_NONE;
        end else begin
            cin_lat_q   <= cin_lat_d;
            cmplx_lat_q <= cmplx_lat_d;
            cmply_lat_q <= cmply_lat_d;
            op_lat_q    <= op_lat_d;
            open_q      <= open_d;
            vld_p1_q    <= vld_p1_d;
            first_p1_q  <= first_p1_d;
            last_p1_q   <= last_p1_d;
            cin_p1_q    <= cin_p1_d;
            op_p1_q     <= op_p1_d;
        end
    end

    // Stage-1 operand data; qualified downstream by vld_p1_q so no reset needed.
    always_ff @(posedge clk) begin
        x_p1_q <= x_p1_d;
        y_p1_q <= y_p1_d;
    end

    // ---- stage 1 / stage 2 boundary ----

    assign c_use_w = first_p1_q ? cin_p1_q : carry_q;

    alu_serial_digit #(
        .DIGIT(DIGIT)
    ) u_digit (
        .x_i          (x_p1_q),
        .y_i          (y_p1_q),
        .c_i          (c_use_w),
        .op_i         (op_p1_q),
        .sum_o        (sum_w),
        .c_out_o      (cout_w),
        .c_into_msb_o (cmsb_w)
    );

    // Carry loop, zero accumulation and status generation for the last digit.
    always_comb begin
        arith_w   = (op_p1_q == OP_ARITH);
        zero_w    = (first_p1_q | zacc_q) & (sum_w == '0);
        carry_d   = carry_q;
        zacc_d    = zacc_q;
        if (vld_p1_q) begin
            carry_d = arith_w & cout_w;
            zacc_d  = last_p1_q ? 1'b1 : zero_w;
        end
        vld_p2_d  = vld_p1_q;
        last_p2_d = vld_p1_q & last_p1_q;
        sum_p2_d  = vld_p1_q ? sum_w : '0;
        co_p2_d   = vld_p1_q & last_p1_q & arith_w & cout_w;
        ov_p2_d   = vld_p1_q & last_p1_q & arith_w & (cout_w ^ cmsb_w);
        z_p2_d    = vld_p1_q & last_p1_q & zero_w;
    end

    // Stage-2 output and loop registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry_q   <= 1'b0;
            zacc_q    <= 1'b1;
            vld_p2_q  <= 1'b0;
            last_p2_q <= 1'b0;
            sum_p2_q  <= '0;
            co_p2_q   <= 1'b0;
            ov_p2_q   <= 1'b0;
            z_p2_q    <= 1'b0;
        end else begin
            carry_q   <= carry_d;
            zacc_q    <= zacc_d;
            vld_p2_q  <= vld_p2_d;
            last_p2_q <= last_p2_d;
            sum_p2_q  <= sum_p2_d;
            co_p2_q   <= co_p2_d;
            ov_p2_q   <= ov_p2_d;
            z_p2_q    <= z_p2_d;
        end
    end

    assign out_valid = vld_p2_q;
    assign out_last  = last_p2_q;
    assign Sum       = sum_p2_q;
    assign Carry_out = co_p2_q;
    assign Overflow  = ov_p2_q;
    assign Zero      = z_p2_q;

endmodule

// File: doc/alu_serial.md
Name: alu_serial

Overview:
- Parametrised digit-serial ALU. It processes operands DIGIT bits per clock, LSB digit first.
- A word is framed by in_first and in_last flags. A carry loop runs across digits.
- Per-word status is reported on the last digit: carry, overflow and zero.
- It is the next-generation arithmetic slice for the serial datapath, replacing the fixed 1-bit slice. It adds configurable digit width, valid/bubble handling, word framing with abort, and a zero flag.

Parameters:
- DIGIT, 1, bits processed per cycle (1..16).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- in_valid  in  1  input digit present this cycle.
- in_first  in  1  digit is the LSB digit of a word; samples word controls.
- in_last  in  1  digit is the MSB digit of a word (End).
- X  in  DIGIT  operand X digit.
- Y  in  DIGIT  operand Y digit.
- Carry_in  in  1  initial carry; sampled with in_first.
- Cmpl_X  in  1  invert X for the whole word; sampled with in_first.
- Cmpl_Y  in  1  invert Y for the whole word; sampled with in_first.
- Op_XOR  in  1  op select; sampled with in_first.
- Op_AND  in  1  op select; sampled with in_first.
- Op_ARITH  in  1  op select; sampled with in_first.
- out_valid  out  1  Sum digit valid.
- out_last  out  1  Sum digit is the last of its word; status outputs valid.
- Sum  out  DIGIT  result digit.
- Carry_out  out  1  word carry-out; meaningful only when out_last=1, else 0.
- Overflow  out  1  signed overflow; meaningful only when out_last=1, else 0.
- Zero  out  1  every Sum digit of the word was 0; meaningful only when out_last=1, else 0.

Behaviour:
- Reset state: all outputs 0, carry register 0, word-open flag 0, zero accumulator 1, latched controls 0. Reset mid-word discards the word; no out_valid follows for it.
- Latency: fixed 2 cycles, in_valid at edge t gives out_valid at edge t+2. Throughput is 1 digit per cycle.
  - Stage 1 registers the complemented operands, framing and latched op.
  - Stage 2 registers Sum and status.
- Word controls: captured when in_valid&in_first and held until the next in_first. Digits inside a word ignore these pins.
- Operand conditioning: x' = X ^ {DIGIT{Cmpl_X}}, y' = Y ^ {DIGIT{Cmpl_Y}}.
- Op priority: ARITH > XOR > AND; none asserted gives Sum=0.
  - ARITH: {c_out, Sum} = x' + y' + c. c is the latched Carry_in on the first digit, else the carry register. The carry register is loaded with c_out on every valid digit.
  - XOR: Sum = x'^y'.
  - AND: Sum = x'&y'.
  - For XOR and AND the carry register is forced to 0.
- Status at last digit, ARITH:
  - Carry_out = c_out.
  - Overflow = carry into MSB bit ^ carry out of MSB bit.
- Status at last digit, non-ARITH: Carry_out=0, Overflow=0.
- Zero: AND of (Sum digit == 0) across the word, including the last digit.
- Bubbles: in_valid=0 changes no state (carry, zero accumulator, word-open). The output stream carries a matching bubble.
- Framing:
  - in_first&in_last together is a single-digit word.
  - in_first while a word is open aborts it: carry and zero are restarted, and the aborted word never gets out_last.
  - A valid digit with in_first=0 while no word is open is dropped, with no out_valid.
  - After in_last the word closes.
- Status outputs are 0 on every cycle where out_last=0.

Decomposition:
- Package alu_serial_pkg holds:
  - op_e enum (OP_NONE, OP_AND, OP_XOR, OP_ARITH) and its priority decode function;
  - DIGIT_MAX=16 constant.
- Sub-module alu_serial_digit is a purely combinational DIGIT-wide slice.
  - Inputs: x', y', c, op.
  - Outputs: Sum, c_out, c_into_msb.
  - The top level keeps all registers, framing and the carry loop.

Test Plan:
1. DIGIT=4, ARITH, Cin=0, X=0x7F, Y=0x01, two digits back-to-back -> Sum digits 0x0, 0x8 at t+2 and t+3; out_last with Carry_out=0, Overflow=1, Zero=0.
2. Subtract: DIGIT=4, ARITH, Cmpl_Y=1, Cin=1, X=0x05, Y=0x05 -> Sum 0x0, 0x0; Carry_out=1, Overflow=0, Zero=1.
3. XOR: DIGIT=4, X=0xA5, Y=0x0F -> Sum 0xA, 0xA; Carry_out=0, Overflow=0, Zero=0. Repeat with AND -> Sum 0x5, 0x0, Zero=0.
4. Bubbles: DIGIT=4, ARITH, X=0xFF, Y=0x01 with 3 idle cycles between the digits -> carry held; Sum 0x0, 0x0 separated by 3 idle cycles; Carry_out=1, Overflow=0, Zero=1.
5. Abort and stray digits: a word is interrupted by a new in_first carrying ARITH 0x1+0x1 (DIGIT=4, single digit, in_last=1) -> no out_last for the aborted word; new result Sum=0x2 with out_last=1. A non-first digit with no open word produces no out_valid.
6. Reset and single-bit mode: DIGIT=1, rst_n pulsed low mid-word -> outputs 0 immediately, no stale out_valid. Then 8-bit word 0x80+0x80 -> Sum bits all 0, Carry_out=1, Overflow=1, Zero=1.
